// File: rtl/spi_master.sv
// spi_master: single-clock master for the 10-bit-frame SPI slave.
// Sends one command frame per accepted start request, one bit per clk
// cycle on SS_n/MOSI. For rd-data frames (word[9:8] = 2'b11) it collects
// the 8-bit response on MISO after READ_LAT cycles.
// Optional build macro SPI_MASTER_ABORT_EN adds an 'abort' input. When
// abort is sampled high in START, CMD, SHIFT, WAIT or RECV, the frame
// moves straight to STOP.
module spi_master #(
    parameter int READ_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [9:0] tx_word,
`ifdef SPI_MASTER_ABORT_EN
    input  logic       abort,
`endif
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_CMD   = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_RECV  = 3'd5;
    localparam logic [2:0] S_STOP  = 3'd6;

    // WAIT lasts READ_LAT-1 cycles. Its count ends at READ_LAT-2.
    localparam logic [3:0] WAIT_LAST = 4'((READ_LAT > 1) ? (READ_LAT - 2) : 0);

    // Slave select is low in every state between acceptance and STOP.
    function automatic logic is_active(input logic [2:0] st);
        logic act;
        case (st)
            S_START, S_CMD, S_SHIFT, S_WAIT, S_RECV: act = 1'b1;
            default:                                 act = 1'b0;
        endcase
        return act;
    endfunction

    logic       abort_s;
    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [9:0] word_q, word_d;
    logic [7:0] shreg_q, shreg_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       rd_valid_q, rd_valid_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       ss_n_q, ss_n_d;
    logic       mosi_q, mosi_d;
    logic [3:0] bit_idx_s;

`ifdef SPI_MASTER_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Frame sequencing: next state, bit counter, captured word, receive shifter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        shreg_d = shreg_q;
        case (state_q)
            S_IDLE: begin
                if (start && !busy_q) begin
                    state_d = S_START;
                    word_d  = tx_word;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (abort_s) begin
                    state_d = S_STOP;
                end else begin
                    state_d = S_CMD;
                end
                cnt_d = 4'd0;
            end
            S_CMD: begin
                if (abort_s) begin
                    state_d = S_STOP;
                end else begin
                    state_d = S_SHIFT;
                end
                cnt_d = 4'd0;
            end
            S_SHIFT: begin
                if (abort_s) begin
                    state_d = S_STOP;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd9) begin
                    cnt_d = 4'd0;
                    if (word_q[9:8] == 2'b11) begin
                        state_d = (READ_LAT == 1) ? S_RECV : S_WAIT;
                    end else begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WAIT: begin
                if (abort_s) begin
                    state_d = S_STOP;
                    cnt_d   = 4'd0;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = S_RECV;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RECV: begin
                if (abort_s) begin
                    state_d = S_STOP;
                    cnt_d   = 4'd0;
                end else begin
                    shreg_d = {shreg_q[6:0], MISO};
                    if (cnt_q == 4'd7) begin
                        state_d = S_STOP;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_STOP: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign bit_idx_s = 4'd9 - cnt_d;

    // Output decode from the next state, so every pin comes straight from a flop.
    always_comb begin
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_STOP);
        ss_n_d   = !is_active(state_d);
        mosi_d   = 1'b0;
        case (state_d)
            S_CMD:   mosi_d = word_d[9];
            S_SHIFT: mosi_d = word_d[bit_idx_s];
            default: mosi_d = 1'b0;
        endcase
        // Only a rd-data frame that finishes RECV normally delivers a byte.
        rd_valid_d = (state_d == S_STOP) && (state_q == S_RECV)
                     && (word_q[9:8] == 2'b11) && !abort_s;
        if (rd_valid_d) begin
            rd_data_d = shreg_d;
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // State and output registers. An asynchronous reset abandons any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            word_q     <= 10'd0;
            shreg_q    <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            shreg_q    <= shreg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign SS_n     = ss_n_q;
    assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed testbench for spi_master. There are three instances, with
// READ_LAT set to 2, 1 and 8. Outputs are sampled 1 time unit after
// each rising edge. Log index n holds the values seen in cycle n of a frame.
module tb_spi_master;

    logic       clk;
    logic       rst_n;
    logic [2:0] start_s;
    logic [9:0] tx_word;
    logic       miso;
    logic       abort_s;
    logic [2:0] busy_o, done_o, rdv_o, ss_o, mosi_o;
    logic [7:0] rdd_o [3];

    int tests = 0;
    int fails = 0;

    logic ss_l   [0:63];
    logic busy_l [0:63];
    int   done_cnt, done_at, rdv_cnt, rdv_at, ss_low;
    logic [10:0] mosi_vec;

    logic a_ss12, a_ss13;
    int   a_done;
    logic [10:0] a_vec;
    int   rst_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    spi_master #(.READ_LAT(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .tx_word(tx_word),
`ifdef SPI_MASTER_ABORT_EN
        .abort(abort_s),
`endif
        .busy(busy_o[0]), .done(done_o[0]), .rd_data(rdd_o[0]), .rd_valid(rdv_o[0]),
        .SS_n(ss_o[0]), .MOSI(mosi_o[0]), .MISO(miso)
    );

    spi_master #(.READ_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .tx_word(tx_word),
`ifdef SPI_MASTER_ABORT_EN
        .abort(1'b0),
`endif
        .busy(busy_o[1]), .done(done_o[1]), .rd_data(rdd_o[1]), .rd_valid(rdv_o[1]),
        .SS_n(ss_o[1]), .MOSI(mosi_o[1]), .MISO(miso)
    );

    spi_master #(.READ_LAT(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .tx_word(tx_word),
`ifdef SPI_MASTER_ABORT_EN
        .abort(1'b0),
`endif
        .busy(busy_o[2]), .done(done_o[2]), .rd_data(rdd_o[2]), .rd_valid(rdv_o[2]),
        .SS_n(ss_o[2]), .MOSI(mosi_o[2]), .MISO(miso)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a frame on DUT sel in the current cycle (cycle 0). Then log cycles 1..ncyc.
    // MISO returns byte b, MSB first, in cycles 12+lat .. 19+lat.
    task automatic run_frame(input logic [1:0] sel, input logic [9:0] w, input logic [7:0] b,
                             input logic [5:0] lat, input logic [5:0] ncyc,
                             input logic [63:0] smask, input logic [63:0] amask);
        logic [5:0] k;
        tx_word      = w;
        start_s      = 3'b000;
        start_s[sel] = 1'b1;
        ss_l[0]      = ss_o[sel];
        busy_l[0]    = busy_o[sel];
        @(posedge clk); #1;
        start_s  = 3'b000;
        tx_word  = ~w;
        done_cnt = 0; done_at = 0; rdv_cnt = 0; rdv_at = 0; ss_low = 0;
        mosi_vec = 11'd0;
        for (logic [5:0] n = 6'd1; n <= ncyc; n++) begin
            ss_l[n]   = ss_o[sel];
            busy_l[n] = busy_o[sel];
            if (done_o[sel]) begin
                done_cnt++;
                if (done_at == 0) done_at = int'(n);
            end
            if (rdv_o[sel]) begin
                rdv_cnt++;
                if (rdv_at == 0) rdv_at = int'(n);
            end
            if (n >= 6'd2 && n <= 6'd12) mosi_vec = {mosi_vec[9:0], mosi_o[sel]};
            if (!ss_o[sel]) ss_low++;
            if (n >= 6'd12 + lat && n <= 6'd19 + lat) begin
                k    = 6'd19 + lat - n;
                miso = b[k[2:0]];
            end else begin
                miso = 1'b0;
            end
            start_s[sel] = smask[n];
            abort_s      = amask[n];
            @(posedge clk); #1;
        end
        start_s = 3'b000;
        abort_s = 1'b0;
        miso    = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        start_s = 3'b000;
        tx_word = 10'd0;
        miso    = 1'b0;
        abort_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_ss",    32'(ss_o),     32'h7);
        check("rst_mosi",  32'(mosi_o),   32'h0);
        check("rst_busy",  32'(busy_o),   32'h0);
        check("rst_done",  32'(done_o),   32'h0);
        check("rst_rdv",   32'(rdv_o),    32'h0);
        check("rst_rdata", 32'(rdd_o[0]), 32'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write-address frame 0A5
        run_frame(2'd0, 10'h0A5, 8'h00, 6'd2, 6'd14, 64'd0, 64'd0);
        check("wa_mosi",   32'(mosi_vec),  32'b00010100101);
        check("wa_done_at", 32'(done_at),  32'd13);
        check("wa_done_cnt", 32'(done_cnt), 32'd1);
        check("wa_rdv_cnt", 32'(rdv_cnt),  32'd0);
        check("wa_ss1",    32'(ss_l[1]),   32'd0);
        check("wa_busy1",  32'(busy_l[1]), 32'd1);
        check("wa_ss13",   32'(ss_l[13]),  32'd1);
        check("wa_busy13", 32'(busy_l[13]), 32'd1);
        check("wa_busy14", 32'(busy_l[14]), 32'd0);

        // Back-to-back: 1C3 then 2A5
        run_frame(2'd0, 10'h1C3, 8'h00, 6'd2, 6'd13, 64'd0, 64'd0);
        a_ss12 = ss_l[12]; a_ss13 = ss_l[13]; a_done = done_at; a_vec = mosi_vec;
        run_frame(2'd0, 10'h2A5, 8'h00, 6'd2, 6'd14, 64'd0, 64'd0);
        check("b2b_a_mosi", 32'(a_vec),   32'b00111000011);
        check("b2b_a_done", 32'(a_done),  32'd13);
        check("b2b_a_ss12", 32'(a_ss12),  32'd0);
        check("b2b_a_ss13", 32'(a_ss13),  32'd1);
        check("b2b_gap_ss", 32'(ss_l[0]), 32'd1);
        check("b2b_b_ss1",  32'(ss_l[1]), 32'd0);
        check("b2b_b_mosi", 32'(mosi_vec), 32'b11010100101);
        check("b2b_b_done", 32'(done_at), 32'd13);

        // Rd-data frame returning 5A, READ_LAT=2
        run_frame(2'd0, 10'h3F0, 8'h5A, 6'd2, 6'd23, 64'd0, 64'd0);
        check("rd2_done_at", 32'(done_at),   32'd22);
        check("rd2_rdv_at",  32'(rdv_at),    32'd22);
        check("rd2_rdv_cnt", 32'(rdv_cnt),   32'd1);
        check("rd2_ss21",    32'(ss_l[21]),  32'd0);
        check("rd2_ss22",    32'(ss_l[22]),  32'd1);
        check("rd2_busy22",  32'(busy_l[22]), 32'd1);
        check("rd2_busy23",  32'(busy_l[23]), 32'd0);
        check("rd2_data",    32'(rdd_o[0]),  32'h5A);

        // READ_LAT=1 and READ_LAT=8 with C3
        run_frame(2'd1, 10'h300, 8'hC3, 6'd1, 6'd22, 64'd0, 64'd0);
        check("rd1_done_at", 32'(done_at),  32'd21);
        check("rd1_rdv_at",  32'(rdv_at),   32'd21);
        check("rd1_data",    32'(rdd_o[1]), 32'hC3);
        run_frame(2'd2, 10'h3C3, 8'hC3, 6'd8, 6'd29, 64'd0, 64'd0);
        check("rd8_done_at", 32'(done_at),  32'd28);
        check("rd8_rdv_at",  32'(rdv_at),   32'd28);
        check("rd8_data",    32'(rdd_o[2]), 32'hC3);

        // Start pulses while busy (cycle 4 and the STOP cycle 13) are ignored
        run_frame(2'd0, 10'h0A5, 8'h00, 6'd2, 6'd30,
                  (64'd1 << 4) | (64'd1 << 13), 64'd0);
        check("bsy_done_cnt", 32'(done_cnt), 32'd1);
        check("bsy_ss_low",   32'(ss_low),   32'd12);
        check("bsy_mosi",     32'(mosi_vec), 32'b00010100101);
        check("bsy_rd_hold",  32'(rdd_o[0]), 32'h5A);

        // Asynchronous reset in cycle 7 of a frame
        tx_word    = 10'h0A5;
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("mid_pre_ss", 32'(ss_o[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_ss",   32'(ss_o[0]),   32'd1);
        check("mid_mosi", 32'(mosi_o[0]), 32'd0);
        check("mid_busy", 32'(busy_o[0]), 32'd0);
        check("mid_rdata", 32'(rdd_o[0]), 32'h00);
        rst_done = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done_o[0]) rst_done++;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (done_o[0]) rst_done++;
        end
        check("mid_no_done", 32'(rst_done), 32'd0);
        run_frame(2'd0, 10'h1C3, 8'h00, 6'd2, 6'd14, 64'd0, 64'd0);
        check("post_rst_mosi", 32'(mosi_vec), 32'b00111000011);
        check("post_rst_done", 32'(done_at),  32'd13);

`ifdef SPI_MASTER_ABORT_EN
        // Load 5A, then abort a rd-data frame in cycle 5
        run_frame(2'd0, 10'h300, 8'h5A, 6'd2, 6'd23, 64'd0, 64'd0);
        check("ab_pre_data", 32'(rdd_o[0]), 32'h5A);
        run_frame(2'd0, 10'h3FF, 8'hFF, 6'd2, 6'd10, 64'd0, (64'd1 << 5));
        check("ab_done_at", 32'(done_at),  32'd6);
        check("ab_done_cnt", 32'(done_cnt), 32'd1);
        check("ab_rdv_cnt", 32'(rdv_cnt),  32'd0);
        check("ab_ss6",     32'(ss_l[6]),  32'd1);
        check("ab_busy7",   32'(busy_l[7]), 32'd0);
        check("ab_data",    32'(rdd_o[0]), 32'h5A);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
